// File: rtl/tdm_demux_8_pkg.sv
// tdm_demux_8_pkg
// Purpose: shared constants and FSM encoding for the 8-slot TDM demultiplexer.
// Contents: slot count, slot index width, index of the last slot, state enum.
package tdm_demux_8_pkg;

   localparam int N_SLOTS = 8;
   localparam int SLOT_W  = 3;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_demux_8_decoder.sv
// decoder_3_8
// Purpose: combinational 3-to-8 one-hot decoder that turns the slot index
//          into per-bit write enables for the shadow register.
// Ports:
//   i_sel     in  SLOT_W   slot index
//   o_onehot  out N_SLOTS  one-hot decode of i_sel
module decoder_3_8
   import tdm_demux_8_pkg::*;
(
   input  logic [SLOT_W-1:0]  i_sel,
   output logic [N_SLOTS-1:0] o_onehot
);

   always_comb begin
      o_onehot        = '0;
      o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux_8.sv
// tdm_demux_8
// Purpose: rebuilds 8 parallel channel bits from a TDM serial stream with a
//          frame-sync marker on slot 0, publishes each complete frame with a
//          one-cycle valid pulse and flags loss of frame alignment.
// Ports:
//   i_clk     in  1  rising-edge clock
//   i_reset   in  1  asynchronous active-high reset
//   i_en      in  1  sample enable (low = stall)
//   i_d       in  1  serial data bit for the current slot
//   i_sync    in  1  marks that i_d belongs to slot 0
//   o_y       out 8  last complete frame, o_y[k] = slot-k bit
//   o_valid   out 1  one-cycle pulse when o_y is updated
//   o_err     out 1  one-cycle pulse on an alignment error
//   o_locked  out 1  high while frame alignment is held
//   o_slot    out 3  slot expected on the next enabled cycle
//
// state    | meaning
// UNLOCKED | hunting for sync, data discarded until sync arrives
// LOCKED   | aligned, each enabled cycle captures the next slot bit
module tdm_demux_8
   import tdm_demux_8_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_en,
   input  logic               i_d,
   input  logic               i_sync,
   output logic [N_SLOTS-1:0] o_y,
   output logic               o_valid,
   output logic               o_err,
   output logic               o_locked,
   output logic [SLOT_W-1:0]  o_slot
);

   state_t               r_state;
   logic [SLOT_W-1:0]    r_slot;
   logic [N_SLOTS-1:0]   r_shadow;
   logic [N_SLOTS-1:0]   r_y;
   logic                 r_valid;
   logic                 r_err;

   state_t               w_state_next;
   logic [SLOT_W-1:0]    w_slot_next;
   logic [N_SLOTS-1:0]   w_shadow_next;
   logic [N_SLOTS-1:0]   w_y_next;
   logic                 w_valid_next;
   logic                 w_err_next;
   logic                 w_capture;
   logic [N_SLOTS-1:0]   w_dec;
   logic [N_SLOTS-1:0]   w_we;

   decoder_3_8 u_decoder (
      .i_sel    (r_slot),
      .o_onehot (w_dec)
   );

   // Normal capture: aligned, and sync agrees with the expected slot position.
   assign w_capture = i_en && (r_state == LOCKED) &&
                      ((r_slot == '0) ? i_sync : !i_sync);
   assign w_we      = w_dec & {N_SLOTS{w_capture}};

   always_comb begin
      w_state_next  = r_state;
      w_slot_next   = r_slot;
      w_shadow_next = r_shadow;
      w_y_next      = r_y;
      w_valid_next  = 1'b0;
      w_err_next    = 1'b0;
      if (w_capture) begin
         for (int k = 0; k < N_SLOTS; k++) begin
            if (w_we[k]) w_shadow_next[k] = i_d;
         end
         w_slot_next = r_slot + SLOT_W'(1);
         if (r_slot == LAST_SLOT) begin
            // Last bit bypasses the shadow so y is complete on this edge.
            w_y_next      = {i_d, r_shadow[N_SLOTS-2:0]};
            w_valid_next  = 1'b1;
            w_shadow_next = '0;
         end
      end else if (i_en) begin
         case (r_state)
            UNLOCKED: begin
               if (i_sync) begin
                  w_shadow_next = {{(N_SLOTS-1){1'b0}}, i_d};
                  w_slot_next   = SLOT_W'(1);
                  w_state_next  = LOCKED;
               end
            end
            LOCKED: begin
               // Only misaligned cycles reach here: early sync restarts the
               // frame, missing sync drops lock.
               w_err_next = 1'b1;
               if (i_sync) begin
                  w_shadow_next = {{(N_SLOTS-1){1'b0}}, i_d};
                  w_slot_next   = SLOT_W'(1);
               end else begin
                  w_shadow_next = '0;
                  w_slot_next   = '0;
                  w_state_next  = UNLOCKED;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= UNLOCKED;
         r_slot   <= '0;
         r_shadow <= '0;
         r_y      <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_slot   <= w_slot_next;
         r_shadow <= w_shadow_next;
         r_y      <= w_y_next;
         r_valid  <= w_valid_next;
         r_err    <= w_err_next;
      end
   end

   assign o_y      = r_y;
   assign o_valid  = r_valid;
   assign o_err    = r_err;
   assign o_locked = (r_state == LOCKED);
   assign o_slot   = r_slot;

endmodule

// File: tb/tb_tdm_demux_8.sv
module tb_tdm_demux_8;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_en;
   logic       i_d;
   logic       i_sync;
   logic [7:0] o_y;
   logic       o_valid;
   logic       o_err;
   logic       o_locked;
   logic [2:0] o_slot;

   tdm_demux_8 dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_en     (i_en),
      .i_d      (i_d),
      .i_sync   (i_sync),
      .o_y      (o_y),
      .o_valid  (o_valid),
      .o_err    (o_err),
      .o_locked (o_locked),
      .o_slot   (o_slot)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int         cyc;
      logic [7:0] y;
   } exp_t;

   exp_t       exp_q[$];
   int         err_q[$];
   int         cyc      = 0;
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] last_y   = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Compares valid/y/err against the scoreboard after every clocked step.
   task automatic check_outputs();
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         check("valid_pulse", {31'd0, o_valid}, 32'd1);
         check("y_frame", {24'd0, o_y}, {24'd0, exp_q[0].y});
         last_y = exp_q[0].y;
         void'(exp_q.pop_front());
      end else begin
         check("valid_idle", {31'd0, o_valid}, 32'd0);
         check("y_hold", {24'd0, o_y}, {24'd0, last_y});
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
         check("err_pulse", {31'd0, o_err}, 32'd1);
         void'(err_q.pop_front());
      end else begin
         check("err_idle", {31'd0, o_err}, 32'd0);
      end
   endtask

   task automatic tick(input logic en, input logic d, input logic sync);
      i_en = en; i_d = d; i_sync = sync;
      @(posedge i_clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_y"},      {24'd0, o_y},      32'd0);
      check({tag, "_valid"},  {31'd0, o_valid},  32'd0);
      check({tag, "_err"},    {31'd0, o_err},    32'd0);
      check({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
      check({tag, "_slot"},   {29'd0, o_slot},   32'd0);
   endtask

   // Full frame starting with sync; expected y lands 8 enabled edges plus
   // any stall cycles after the first edge.
   task automatic send_frame(input logic [7:0] b, input int stall_at,
                             input int stall_n, input bit exp_err);
      exp_q.push_back('{cyc + 8 + stall_n, b});
      if (exp_err) err_q.push_back(cyc + 1);
      for (int k = 0; k < 8; k++) begin
         tick(1'b1, b[k], k == 0);
         check("slot_adv", {29'd0, o_slot}, 32'((k + 1) % 8));
         check("locked_frame", {31'd0, o_locked}, 32'd1);
         if (k == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               tick(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
               check("slot_stall", {29'd0, o_slot}, 32'((k + 1) % 8));
            end
         end
      end
   endtask

   // First n slots of a frame, no completion expected.
   task automatic partial_frame(input logic [7:0] b, input int n);
      for (int k = 0; k < n; k++) tick(1'b1, b[k], k == 0);
   endtask

   initial begin
      // Reset with random inputs
      i_reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         i_en = 1'($urandom_range(1)); i_d = 1'($urandom_range(1));
         i_sync = 1'($urandom_range(1));
         @(posedge i_clk);
         #1;
      end
      check_reset_outputs("reset");
      i_reset = 1'b0;
      i_en = 1'b0; i_d = 1'b0; i_sync = 1'b0;

      // Back-to-back normal frames
      send_frame(8'h4D, -1, 0, 1'b0);
      send_frame(8'hA5, -1, 0, 1'b0);

      // Stall of 3 cycles after slot 3
      send_frame(8'h4D, 3, 3, 1'b0);

      // Early sync at slot 4: restart frame, err on the new sync edge
      partial_frame(8'hFF, 4);
      check("slot_before_early", {29'd0, o_slot}, 32'd4);
      send_frame(8'h30, -1, 0, 1'b1);

      // Missing sync at slot 0 while locked
      err_q.push_back(cyc + 1);
      tick(1'b1, 1'b1, 1'b0);
      check("locked_after_miss", {31'd0, o_locked}, 32'd0);
      check("slot_after_miss", {29'd0, o_slot}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'($urandom_range(1)), 1'b0);
         check("unlocked_hunt", {31'd0, o_locked}, 32'd0);
      end
      send_frame(8'h96, -1, 0, 1'b0);

      // Asynchronous reset at slot 5
      partial_frame(8'hFF, 5);
      check("slot_before_reset", {29'd0, o_slot}, 32'd5);
      i_reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      last_y = 8'h00;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      tick(1'b1, 1'b1, 1'b0);
      check("unlocked_after_reset", {31'd0, o_locked}, 32'd0);
      send_frame(8'h21, -1, 0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("err_q_drained", 32'(err_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
